btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_channel.sv | 172 +++++++++++++++++
 rtl/btn_conditioner.sv | 50 +++++
 tb/tb_btn_conditioner.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: per-channel FSM state
// encoding, debounce counter width and default parameter values.
package btn_pkg;

    // Debounce counter width; DB_CYCLES must fit below 2^CNT_W.
    localparam int unsigned CNT_W          = 20;
    localparam int unsigned DB_MAX         = (32'd1 << CNT_W) - 32'd1;

    // Defaults sized for a 50 MHz clock.
    localparam int unsigned DEF_N          = 4;
    localparam int unsigned DEF_DB_CYCLES  = 500000;    // 10 ms
    localparam int unsigned DEF_RPT_DELAY  = 25000000;  // 500 ms
    localparam int unsigned DEF_RPT_PERIOD = 5000000;   // 100 ms

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CONF_HI   = 2'd1,
        STABLE_HI = 2'd2,
        CONF_LO   = 2'd3
    } btn_state_e;

endpackage : btn_pkg

// File: rtl/btn_channel.sv
// One button channel: two-flop synchronizer, debounce FSM with a saturating
// confirmation counter, and (optionally) an auto-repeat generator.
//
// Optional feature: define BTN_CONDITIONER_AUTOREPEAT_EN to build the
// auto-repeat counter; otherwise rpt is tied to 0.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   raw         asynchronous raw button level (1 = pressed)
//   level       debounced level
//   press       one-cycle pulse on accepted 0->1
//   rel         one-cycle pulse on accepted 1->0
//   rpt         one-cycle auto-repeat pulses while held
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
    parameter int unsigned RPT_DELAY  = DEF_RPT_DELAY,
    parameter int unsigned RPT_PERIOD = DEF_RPT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DB_CYCLES - 32'd1);

    logic             sync_q1;
    logic             sample;
    btn_state_e       state;
    btn_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             rel_nxt;

    // Two-flop synchronizer; sample is the metastability-safe copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sample  <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sample  <= sync_q1;
        end
    end

    // FSM state, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            press <= press_nxt;
            rel   <= rel_nxt;
        end
    end

    // Next-state logic. The counter only advances below CNT_TERM, so it
    // saturates; acceptance happens on the edge that sees CNT_TERM.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        unique case (state)
            STABLE_LO: begin
                level_nxt = 1'b0;
                if (sample) begin
                    state_nxt = CONF_HI;
                    cnt_nxt   = '0;
                end
            end
            CONF_HI: begin
                if (!sample) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_TERM) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STABLE_HI: begin
                level_nxt = 1'b1;
                if (!sample) begin
                    state_nxt = CONF_LO;
                    cnt_nxt   = '0;
                end
            end
            CONF_LO: begin
                if (sample) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_TERM) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                    rel_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = STABLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 32'd1);
    localparam logic [RPT_W-1:0] DELAY_TERM  = RPT_W'(RPT_DELAY - 32'd1);
    localparam logic [RPT_W-1:0] PERIOD_TERM = RPT_W'(RPT_PERIOD - 32'd1);

    logic [RPT_W-1:0] rcnt;
    logic [RPT_W-1:0] rcnt_nxt;
    logic             rdone;      // first repeat already issued
    logic             rdone_nxt;
    logic             rpt_nxt;

    // Counts only while the held level is still being sampled; any exit from
    // STABLE_HI clears it. It is zero on the press edge, so no repeat can
    // coincide with press.
    always_comb begin
        rcnt_nxt  = '0;
        rdone_nxt = 1'b0;
        rpt_nxt   = 1'b0;
        if (state == STABLE_HI && sample) begin
            rdone_nxt = rdone;
            if (rcnt == (rdone ? PERIOD_TERM : DELAY_TERM)) begin
                rpt_nxt   = 1'b1;
                rcnt_nxt  = '0;
                rdone_nxt = 1'b1;
            end else begin
                rcnt_nxt = rcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt  <= '0;
            rdone <= 1'b0;
            rpt   <= 1'b0;
        end else begin
            rcnt  <= rcnt_nxt;
            rdone <= rdone_nxt;
            rpt   <= rpt_nxt;
        end
    end
`else
    assign rpt = 1'b0;
`endif

endmodule : btn_channel

// File: rtl/btn_conditioner.sv
// N-channel button conditioner: per-channel synchronize, debounce, edge
// pulses and optional auto-repeat (BTN_CONDITIONER_AUTOREPEAT_EN).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   btn_raw      [N] raw asynchronous levels, 1 = pressed
//   btn_level    [N] debounced level
//   btn_press    [N] one-cycle pulse per accepted press
//   btn_release  [N] one-cycle pulse per accepted release
//   btn_repeat   [N] auto-repeat pulses (0 when the feature is compiled out)
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N          = DEF_N,
    parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
    parameter int unsigned RPT_DELAY  = DEF_RPT_DELAY,
    parameter int unsigned RPT_PERIOD = DEF_RPT_PERIOD
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic [N-1:0] btn_repeat
);

    // Reject configurations the counters cannot represent.
    if (DB_CYCLES < 2 || DB_CYCLES > DB_MAX || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_cfg
        $error("btn_conditioner: parameter out of range");
    end

    // Fully independent channels.
    for (genvar i = 0; i < N; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES  (DB_CYCLES),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .press (btn_press[i]),
            .rel   (btn_release[i]),
            .rpt   (btn_repeat[i])
        );
    end

endmodule : btn_conditioner

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_CYCLES=4, RPT_DELAY=10,
// RPT_PERIOD=3. Inputs change on the falling edge; outputs are sampled on
// the falling edge after each rising edge. With a change applied before
// rising edge t (k=1), outputs update after edge t+2+DB_CYCLES, i.e. k=7.
module tb_btn_conditioner;

    localparam int unsigned N  = 4;
    localparam int unsigned DB = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_repeat;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N          (N),
        .DB_CYCLES  (DB),
        .RPT_DELAY  (RD),
        .RPT_PERIOD (RP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [N-1:0] lvl,
                            input logic [N-1:0] prs, input logic [N-1:0] rel);
        chk({tag, " level"},   32'(btn_level),   32'(lvl));
        chk({tag, " press"},   32'(btn_press),   32'(prs));
        chk({tag, " release"}, 32'(btn_release), 32'(rel));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] exp_rpt;

        // Reset held: everything zero even with clocks running.
        rst_n   = 1'b0;
        btn_raw = '0;
        step();
        step();
        chk_outs("reset", 4'b0000, 4'b0000, 4'b0000);
        chk("reset repeat", 32'(btn_repeat), 32'd0);
        rst_n = 1'b1;
        step();
        chk_outs("post reset", 4'b0000, 4'b0000, 4'b0000);

        // Clean press on channel 0.
        btn_raw = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk_outs($sformatf("press0 k=%0d", k),
                     (k >= 7) ? 4'b0001 : 4'b0000,
                     (k == 7) ? 4'b0001 : 4'b0000,
                     4'b0000);
        end

        // Release on channel 0.
        btn_raw = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk_outs($sformatf("release0 k=%0d", k),
                     (k < 7)  ? 4'b0001 : 4'b0000,
                     4'b0000,
                     (k == 7) ? 4'b0001 : 4'b0000);
        end

        // Bounce on channel 1: 1,0,1,0 for two cycles each, then low.
        for (int p = 0; p < 4; p++) begin
            btn_raw = (p % 2 == 0) ? 4'b0010 : 4'b0000;
            for (int c = 0; c < 2; c++) begin
                step();
                chk_outs($sformatf("bounce p=%0d c=%0d", p, c), 4'b0000, 4'b0000, 4'b0000);
            end
        end
        btn_raw = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk_outs($sformatf("bounce tail k=%0d", k), 4'b0000, 4'b0000, 4'b0000);
        end

        // Simultaneous press and release on channels 1 and 3.
        btn_raw = 4'b1010;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk_outs($sformatf("simul press k=%0d", k),
                     (k >= 7) ? 4'b1010 : 4'b0000,
                     (k == 7) ? 4'b1010 : 4'b0000,
                     4'b0000);
        end
        btn_raw = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk_outs($sformatf("simul release k=%0d", k),
                     (k < 7)  ? 4'b1010 : 4'b0000,
                     4'b0000,
                     (k == 7) ? 4'b1010 : 4'b0000);
        end

        // Reset in the middle of a confirmation on channel 2.
        btn_raw = 4'b0100;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_outs($sformatf("pre-reset k=%0d", k), 4'b0000, 4'b0000, 4'b0000);
        end
        rst_n = 1'b0;
        #1;
        chk_outs("mid reset async", 4'b0000, 4'b0000, 4'b0000);
        step();
        step();
        chk_outs("mid reset held", 4'b0000, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk_outs($sformatf("after reset k=%0d", k),
                     (k >= 7) ? 4'b0100 : 4'b0000,
                     (k == 7) ? 4'b0100 : 4'b0000,
                     4'b0000);
        end
        btn_raw = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk_outs($sformatf("after reset rel k=%0d", k),
                     (k < 7)  ? 4'b0100 : 4'b0000,
                     4'b0000,
                     (k == 7) ? 4'b0100 : 4'b0000);
        end

        // Long hold on channel 3: press at k=7, raw dropped after k=29,
        // release at k=36. Repeats at press+10 then every 3 cycles.
        btn_raw = 4'b1000;
        for (int k = 1; k <= 45; k++) begin
            step();
            chk_outs($sformatf("hold3 k=%0d", k),
                     (k >= 7 && k < 36) ? 4'b1000 : 4'b0000,
                     (k == 7)  ? 4'b1000 : 4'b0000,
                     (k == 36) ? 4'b1000 : 4'b0000);
            exp_rpt = 4'b0000;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
            if (k == 17 || k == 20 || k == 23 || k == 26 || k == 29)
                exp_rpt = 4'b1000;
`endif
            chk($sformatf("hold3 k=%0d repeat", k), 32'(btn_repeat), 32'(exp_rpt));
            if (k == 29)
                btn_raw = 4'b0000;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_btn_conditioner
